// File: rtl/pwm_multi_pkg.sv
// Shared types and helpers for the multi-channel PWM controller.
package pwm_multi_pkg;

  // Extra bit carried by the phase counter so that cnt + offset cannot overflow.
  localparam int CNT_HEADROOM = 1;
  localparam int SAT_W        = 32;

  typedef enum logic {
    STABLE   = 1'b0,
    CHANGING = 1'b1
  } deb_state_t;

  // Step up or down, clamped to [0, lim]. Operands are wide enough that the sum cannot wrap.
  function automatic logic [SAT_W-1:0] sat_step(
    input logic [SAT_W-1:0] cur,
    input logic [SAT_W-1:0] step,
    input logic [SAT_W-1:0] lim,
    input logic             up
  );
    logic [SAT_W-1:0] sum;
    sum = cur + step;
    if (up) begin
      return (sum > lim) ? lim : sum;
    end
    return (cur < step) ? '0 : cur - step;
  endfunction

endpackage

// File: rtl/pwm_btn_debounce.sv
// Button debouncer: 2-flop synchroniser, DEB_CNT-tick run filter, single press pulse on 0->1.
// Latency: 2 cycles sync + DEB_CNT ticks + 1 cycle to the press pulse.
// Backpressure: none; one pulse per accepted press, holding does not repeat.
module pwm_btn_debounce #(
  parameter int DEB_CNT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic btn,
  output logic press
);
  import pwm_multi_pkg::*;

  localparam int RW = $clog2(DEB_CNT + 1);

  logic [1:0]    sync_q;
  logic          stable;
  logic          stable_d;
  logic [RW-1:0] run_cnt;
  deb_state_t    state;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      run_cnt  <= '0;
      state    <= STABLE;
    end else begin
      sync_q   <= {sync_q[0], btn};
      stable_d <= stable;
      if (tick) begin
        if (sync_q[1] == stable) begin
          run_cnt <= '0;
          state   <= STABLE;
        end else if (run_cnt == RW'(DEB_CNT - 1)) begin
          // Enough consecutive differing samples: accept the new level.
          stable  <= sync_q[1];
          run_cnt <= '0;
          state   <= STABLE;
        end else if (state == STABLE) begin
          run_cnt <= RW'(1);
          state   <= CHANGING;
        end else begin
          run_cnt <= run_cnt + 1'b1;
        end
      end
    end
  end

  assign press = stable & ~stable_d;

endmodule

// File: rtl/pwm_multi_ctrl.sv
// NCH-channel PWM with debounced duty buttons; duty shadowed to the period wrap (PWM_PHASE_STAGGER_EN staggers phases).
// Latency: pwm_out registered, 1 cycle behind the period counter; new duty visible after the next wrap.
// Backpressure: none; simultaneous inc and dec on one channel cancel.
module pwm_multi_ctrl #(
  parameter int NCH       = 4,
  parameter int CNT_W     = 8,
  parameter int PERIOD    = 200,
  parameter int STEP      = 20,
  parameter int DUTY_INIT = 100,
  parameter int DEB_DIV   = 250000,
  parameter int DEB_CNT   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [NCH-1:0]       inc_btn,
  input  logic [NCH-1:0]       dec_btn,
  output logic [NCH-1:0]       pwm_out,
  output logic [NCH*CNT_W-1:0] duty_o,
  output logic                 period_wrap
);
  import pwm_multi_pkg::*;

  localparam int PW     = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
  localparam int CNT_WH = CNT_W + CNT_HEADROOM;
`ifdef PWM_PHASE_STAGGER_EN
  localparam int PH_STEP = PERIOD / NCH;
`else
  localparam int PH_STEP = 0;
`endif

  logic [PW-1:0]     presc;
  logic              tick;
  logic [CNT_W-1:0]  cnt;
  logic              wrap;
  logic [NCH-1:0]    inc_p;
  logic [NCH-1:0]    dec_p;
  logic [CNT_W-1:0]  duty_pend [NCH];
  logic [CNT_W-1:0]  duty_act  [NCH];
  logic [CNT_WH-1:0] ph_sum    [NCH];
  logic [CNT_WH-1:0] ph_cnt    [NCH];

  // Debounce prescaler, free-running regardless of en.
  assign tick = (presc == PW'(DEB_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
    end
  end

  assign wrap        = en && (cnt == CNT_W'(PERIOD - 1));
  assign period_wrap = wrap;

  always_ff @(posedge clk) begin
    if (rst || !en || wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    pwm_btn_debounce #(.DEB_CNT(DEB_CNT)) u_inc (
      .clk   (clk),
      .rst   (rst),
      .tick  (tick),
      .btn   (inc_btn[i]),
      .press (inc_p[i])
    );

    pwm_btn_debounce #(.DEB_CNT(DEB_CNT)) u_dec (
      .clk   (clk),
      .rst   (rst),
      .tick  (tick),
      .btn   (dec_btn[i]),
      .press (dec_p[i])
    );

    assign ph_sum[i] = CNT_WH'(cnt) + CNT_WH'(i * PH_STEP);
    assign ph_cnt[i] = (ph_sum[i] >= CNT_WH'(PERIOD)) ? ph_sum[i] - CNT_WH'(PERIOD) : ph_sum[i];
    assign duty_o[i*CNT_W +: CNT_W] = duty_act[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_out <= '0;
      for (int i = 0; i < NCH; i++) begin
        duty_pend[i] <= CNT_W'(DUTY_INIT);
        duty_act[i]  <= CNT_W'(DUTY_INIT);
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (inc_p[i] != dec_p[i]) begin
          duty_pend[i] <= CNT_W'(sat_step(SAT_W'(duty_pend[i]), SAT_W'(STEP),
                                          SAT_W'(PERIOD), inc_p[i]));
        end
        // Shadow load only at the boundary so no pulse is ever truncated mid-period.
        if (wrap || !en) begin
          duty_act[i] <= duty_pend[i];
        end
        pwm_out[i] <= en && (ph_cnt[i] < CNT_WH'(duty_act[i]));
      end
    end
  end

endmodule

// File: tb/tb_pwm_multi_ctrl.sv
// Directed bench for pwm_multi_ctrl with a cycle-level reference model and literal spot checks.
module tb_pwm_multi_ctrl;

  localparam int NCH       = 2;
  localparam int CNT_W     = 8;
  localparam int PERIOD    = 10;
  localparam int STEP      = 3;
  localparam int DUTY_INIT = 5;
  localparam int DEB_DIV   = 4;
  localparam int DEB_CNT   = 2;
  localparam int NB        = 2 * NCH;
`ifdef PWM_PHASE_STAGGER_EN
  localparam int PH_OFF = PERIOD / NCH;
  localparam int LAG    = PERIOD / NCH;
`else
  localparam int PH_OFF = 0;
  localparam int LAG    = 0;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 en  = 1'b0;
  logic [NCH-1:0]       inc_btn = '0;
  logic [NCH-1:0]       dec_btn = '0;
  logic [NCH-1:0]       pwm_out;
  logic [NCH*CNT_W-1:0] duty_o;
  logic                 period_wrap;

  int n_cmp = 0;
  int n_err = 0;
  logic chk_on = 1'b0;

  pwm_multi_ctrl #(
    .NCH(NCH), .CNT_W(CNT_W), .PERIOD(PERIOD), .STEP(STEP),
    .DUTY_INIT(DUTY_INIT), .DEB_DIV(DEB_DIV), .DEB_CNT(DEB_CNT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .inc_btn     (inc_btn),
    .dec_btn     (dec_btn),
    .pwm_out     (pwm_out),
    .duty_o      (duty_o),
    .period_wrap (period_wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: counter, shadowed duty, and a sliding-window view of the debouncer.
  int   m_cnt, m_presc;
  int   m_pend [NCH];
  int   m_act  [NCH];
  logic m_pwm  [NCH];
  logic m_hist0 [NB];
  logic m_hist1 [NB];
  logic m_stable [NB];
  logic m_press [NB];
  logic m_win [NB][DEB_CNT];

  always @(posedge clk) begin : model_blk
    logic          wrap, tick, samp, all_diff;
    int            ph;
    logic [NB-1:0] btn_now;
    btn_now = {dec_btn, inc_btn};
    if (rst) begin
      m_cnt   = 0;
      m_presc = 0;
      for (int i = 0; i < NCH; i++) begin
        m_pend[i] = DUTY_INIT;
        m_act[i]  = DUTY_INIT;
        m_pwm[i]  = 1'b0;
      end
      for (int b = 0; b < NB; b++) begin
        m_hist0[b] = 1'b0; m_hist1[b] = 1'b0;
        m_stable[b] = 1'b0; m_press[b] = 1'b0;
        for (int k = 0; k < DEB_CNT; k++) m_win[b][k] = 1'b0;
      end
    end else begin
      wrap = en && (m_cnt == PERIOD - 1);
      for (int i = 0; i < NCH; i++) begin
        ph = (m_cnt + i * PH_OFF) % PERIOD;
        m_pwm[i] = en && (ph < m_act[i]);
      end
      for (int i = 0; i < NCH; i++) begin
        if (wrap || !en) m_act[i] = m_pend[i];
      end
      for (int i = 0; i < NCH; i++) begin
        if (m_press[i] && !m_press[NCH+i])
          m_pend[i] = (m_pend[i] + STEP > PERIOD) ? PERIOD : m_pend[i] + STEP;
        else if (!m_press[i] && m_press[NCH+i])
          m_pend[i] = (m_pend[i] < STEP) ? 0 : m_pend[i] - STEP;
      end
      m_cnt   = (!en || wrap) ? 0 : m_cnt + 1;
      tick    = (m_presc == DEB_DIV - 1);
      m_presc = tick ? 0 : m_presc + 1;
      for (int b = 0; b < NB; b++) begin
        m_press[b] = 1'b0;
        samp = m_hist1[b];
        if (tick) begin
          for (int k = DEB_CNT - 1; k > 0; k--) m_win[b][k] = m_win[b][k-1];
          m_win[b][0] = samp;
          all_diff = 1'b1;
          for (int k = 0; k < DEB_CNT; k++) if (m_win[b][k] == m_stable[b]) all_diff = 1'b0;
          if (all_diff) begin
            m_stable[b] = samp;
            m_press[b]  = samp;
          end
        end
        m_hist1[b] = m_hist0[b];
        m_hist0[b] = btn_now[b];
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < NCH; i++) begin
        chk("pwm_out", 32'(pwm_out[i]), 32'(m_pwm[i]));
        chk("duty_o", 32'(duty_o[i*CNT_W +: CNT_W]), 32'(m_act[i]));
      end
      chk("period_wrap", 32'(period_wrap), 32'(en && (m_cnt == PERIOD - 1)));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [NCH-1:0] im, input logic [NCH-1:0] dm);
    inc_btn = im; dec_btn = dm;
    step(16);
    inc_btn = '0; dec_btn = '0;
    step(16);
  endtask

  task automatic duty_after(input string nm, input int ch, input int exp);
    step(12);
    @(negedge clk);
    chk(nm, 32'(duty_o[ch*CNT_W +: CNT_W]), 32'(exp));
  endtask

  task automatic count_highs(input int n, output int h0, output int h1, output int w);
    h0 = 0; h1 = 0; w = 0;
    repeat (n) begin
      @(negedge clk);
      h0 += int'(pwm_out[0]);
      h1 += int'(pwm_out[1]);
      w  += int'(period_wrap);
    end
  endtask

  initial begin : timeout
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int h0, h1, w, t0, t1;
    int inc_exp[4];
    int dec_exp[5];
    logic p0, p1;
    inc_exp = '{8, 10, 10, 10};
    dec_exp = '{7, 4, 1, 0, 0};

    step(1);
    chk_on = 1'b1;
    step(2);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_duty", 32'(duty_o), 32'h0505);
    chk("reset_pwm", 32'(pwm_out), 0);
    chk("reset_wrap", 32'(period_wrap), 0);

    en = 1'b1;
    step(2);
    count_highs(20, h0, h1, w);
    chk("init_high0_20cyc", h0, 10);
    chk("init_wraps_20cyc", w, 2);

    press(2'b01, 2'b00);
    duty_after("inc_ch0", 0, 8);
    chk("ch1_untouched", 32'(duty_o[15:8]), 5);
    count_highs(10, h0, h1, w);
    chk("high0_duty8", h0, 8);
    chk("high1_duty5", h1, 5);

    for (int k = 0; k < 4; k++) begin
      press(2'b10, 2'b00);
      duty_after($sformatf("inc_ch1_%0d", k), 1, inc_exp[k]);
    end
    count_highs(10, h0, h1, w);
    chk("high1_saturated", h1, 10);

    for (int k = 0; k < 5; k++) begin
      press(2'b00, 2'b10);
      duty_after($sformatf("dec_ch1_%0d", k), 1, dec_exp[k]);
    end
    count_highs(10, h0, h1, w);
    chk("high1_zero", h1, 0);

    repeat (4) begin
      inc_btn[0] = 1'b1; step(3);
      inc_btn[0] = 1'b0; step(5);
    end
    step(20);
    duty_after("bounce_no_change", 0, 8);

    press(2'b01, 2'b01);
    duty_after("inc_dec_cancel", 0, 8);

    for (int k = 0; k < 20; k++) begin
      if (m_cnt == 2) break;
      step(1);
    end
    en = 1'b0;
    step(1);
    @(negedge clk);
    chk("en0_pwm_low", 32'(pwm_out), 0);
    chk("en0_wrap_low", 32'(period_wrap), 0);
    press(2'b00, 2'b01);
    @(negedge clk);
    chk("en0_dec_immediate", 32'(duty_o[7:0]), 5);

    en = 1'b1;
    step(13);
    rst = 1'b1;
    step(1);
    @(negedge clk);
    chk("midrst_duty", 32'(duty_o), 32'h0505);
    chk("midrst_pwm", 32'(pwm_out), 0);
    chk("midrst_wrap", 32'(period_wrap), 0);
    step(1);
    rst = 1'b0;

    t0 = -1; t1 = -1; p0 = 1'b0; p1 = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (t0 < 0 && pwm_out[0] && !p0) t0 = n;
      if (t1 < 0 && pwm_out[1] && !p1) t1 = n;
      p0 = pwm_out[0];
      p1 = pwm_out[1];
    end
    chk("rise0_found", 32'(t0 >= 0), 1);
    chk("rise1_found", 32'(t1 >= 0), 1);
    chk("rise_lag", 32'(t1 - t0), 32'(LAG));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
